sdp_rdma_rd_arb: RTL and testbench
==================================

Name: sdp_rdma_rd_arb

Overview:
Shares one DMA read-request/response port among NREQ SDP read-DMA engines (MRDMA, BRDMA, NRDMA, ERDMA). It sits between the engines and the SDP RDMA DMA interface. Requests are granted round-robin. Each granted request's requester ID is recorded in an in-order tag FIFO, and each returning response is routed to the requester at the FIFO head. Latency-FIFO credit-pop pulses from all requesters are merged onto the single DMA credit-pop line.

Parameters:
NREQ, 4, number of requesters (2..8)
REQ_W, 79, DMA read-request payload width
RSP_W, 514, DMA read-response payload width
TAG_DEPTH, 16, outstanding-request tag FIFO depth per ram type (power of 2)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  synchronous active-high reset
req_vld  in  NREQ  per-requester request valid
req_rdy  out  NREQ  per-requester request ready
req_pd  in  NREQ*REQ_W  request payloads; requester i occupies [i*REQ_W +: REQ_W]
req_ram_type  in  NREQ  per-requester target (0=MC, 1=CV)
dma_rd_req_vld  out  1  arbitrated request valid
dma_rd_req_rdy  in  1  DMA request ready
dma_rd_req_pd  out  REQ_W  arbitrated payload
dma_rd_req_ram_type  out  1  arbitrated ram type
dma_rd_rsp_vld  in  1  response valid
dma_rd_rsp_rdy  out  1  response ready
dma_rd_rsp_pd  in  RSP_W  response payload
dma_rd_rsp_ram_type  in  1  interface the response came from
rsp_vld  out  NREQ  per-requester response valid (one-hot or zero)
rsp_rdy  in  NREQ  per-requester response ready
rsp_pd  out  RSP_W  response payload, broadcast to all requesters
cdt_pop  in  NREQ  per-requester latency-FIFO pop pulses
dma_rd_cdt_lat_fifo_pop  out  1  merged credit pop, at most one per cycle
arb_idle  out  1  all tag FIFOs empty and no pending credit pops
rsp_underflow  out  1  sticky error flag

Behaviour:
- Reset values: all tag FIFOs empty; round-robin last-grant pointer = NREQ-1 (so requester 0 wins first); grant lock cleared; credit counter 0. Outputs after reset: dma_rd_req_vld=0, req_rdy=0, rsp_vld=0, dma_rd_rsp_rdy=0, dma_rd_cdt_lat_fifo_pop=0, rsp_underflow=0, arb_idle=1.
- Eligibility: requester i is eligible when req_vld[i]=1 and the tag FIFO for req_ram_type[i] is not full.
- Arbitration (combinational, zero latency):
  - With no lock, grant the first eligible requester searching upward from last+1 modulo NREQ.
  - dma_rd_req_vld = a grant exists. pd and ram_type are muxed from the granted requester.
  - req_rdy[g] = dma_rd_req_rdy. All other req_rdy bits are 0.
- Grant lock: if dma_rd_req_vld=1 and dma_rd_req_rdy=0, the grant is registered and held on following cycles until accepted. The payload must not change while stalled.
- On request handshake:
  - Push g into the tag FIFO selected by ram_type.
  - Update last=g and clear the lock.
- Response routing:
  - h = head of the tag FIFO selected by dma_rd_rsp_ram_type.
  - If that FIFO is non-empty: rsp_vld[h] = dma_rd_rsp_vld, dma_rd_rsp_rdy = rsp_rdy[h], rsp_pd = dma_rd_rsp_pd.
  - On response handshake, pop that FIFO.
- Empty-FIFO response: if dma_rd_rsp_vld=1 while the selected FIFO is empty:
  - dma_rd_rsp_rdy=0 and rsp_vld=0.
  - rsp_underflow is set and stays set until reset.
- Push and pop on the same FIFO in one cycle: both take effect and the count is unchanged. A push while full cannot occur, because the requester is not eligible.
- Credit merge:
  - Counter cnt, width clog2(NREQ*TAG_DEPTH)+1.
  - Each cycle: cnt_next = cnt + popcount(cdt_pop) - (cnt != 0).
  - dma_rd_cdt_lat_fifo_pop = (cnt != 0).
  - The counter saturates at its maximum; it never wraps.
- arb_idle = all FIFOs empty && cnt == 0 && no lock.
- Reset mid-operation: all state clears in the same cycle. Outstanding responses are the system's responsibility.

Optional Feature:
SDP_RDARB_SECONDARY_MEMIF_EN
- Defined: two independent tag FIFOs (MC and CV), selected by req_ram_type on push and dma_rd_rsp_ram_type on pop. This allows responses from the two interfaces to return out of order relative to each other.
- Undefined:
  - A single tag FIFO.
  - req_ram_type and dma_rd_rsp_ram_type are ignored; dma_rd_req_ram_type = 0.

Test Plan:
- All 4 requesters hold req_vld=1 with dma_rd_req_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles; responses return in order, each rsp_vld going to that sequence.
- Requester 2 granted with dma_rd_req_rdy=0 for 5 cycles while requester 1 also requests -> grant stays on 2 and pd is stable; requester 1 is granted on the cycle after acceptance.
- 16 MC requests issued with no responses -> 17th MC request sees req_rdy=0; a CV request is still accepted (feature defined); one MC response frees one slot.
- MC tag FIFO head = requester 3, CV head = requester 1; a CV response arrives first -> rsp_vld[1]=1; then an MC response -> rsp_vld[3]=1.
- cdt_pop=4'b1111 in one cycle -> dma_rd_cdt_lat_fifo_pop high for exactly 4 consecutive cycles; arb_idle returns to 1 afterwards.
- Response valid with all FIFOs empty -> dma_rd_rsp_rdy=0 and rsp_underflow=1 persisting; nvdla_core_rst=1 clears it to 0.

Source files
------------

// File: rtl/sdp_rdma_rd_arb.sv
// ---------------------------------------------------------------------------
// sdp_rdma_rd_arb
// Shares one DMA read-request/response port among NREQ SDP read-DMA engines.
// Requests are granted round-robin. Each accepted request records its
// requester ID in an in-order tag FIFO. Each returning response is routed to
// the requester at the head of that FIFO. Latency-FIFO credit-pop pulses from
// all engines are merged onto the single DMA credit-pop line. That line pops
// at most one credit per cycle.
//
// Optional feature macro: SDP_RDARB_SECONDARY_MEMIF_EN
//   defined   : separate MC and CV tag FIFOs, so responses from the two
//               memory interfaces may return out of order with respect to
//               each other.
//   undefined : a single tag FIFO. Ram-type inputs are ignored and
//               dma_rd_req_ram_type is tied to 0.
//
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   req_vld/req_rdy/req_pd/req_ram_type : per-engine read requests
//   dma_rd_req_*                    : arbitrated request towards the DMA
//   dma_rd_rsp_*                    : returning DMA responses
//   rsp_vld/rsp_rdy/rsp_pd          : per-engine responses (pd broadcast)
//   cdt_pop                         : per-engine latency-FIFO pop pulses
//   dma_rd_cdt_lat_fifo_pop         : merged credit pop
//   arb_idle                        : nothing outstanding, nothing pending
//   rsp_underflow                   : sticky, response seen with no tag
// ---------------------------------------------------------------------------
module sdp_rdma_rd_arb #(
    parameter int NREQ      = 4,
    parameter int REQ_W     = 79,
    parameter int RSP_W     = 514,
    parameter int TAG_DEPTH = 16
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic [NREQ-1:0]       req_vld,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*REQ_W-1:0] req_pd,
    input  logic [NREQ-1:0]       req_ram_type,
    output logic                  dma_rd_req_vld,
    input  logic                  dma_rd_req_rdy,
    output logic [REQ_W-1:0]      dma_rd_req_pd,
    output logic                  dma_rd_req_ram_type,
    input  logic                  dma_rd_rsp_vld,
    output logic                  dma_rd_rsp_rdy,
    input  logic [RSP_W-1:0]      dma_rd_rsp_pd,
    input  logic                  dma_rd_rsp_ram_type,
    output logic [NREQ-1:0]       rsp_vld,
    input  logic [NREQ-1:0]       rsp_rdy,
    output logic [RSP_W-1:0]      rsp_pd,
    input  logic [NREQ-1:0]       cdt_pop,
    output logic                  dma_rd_cdt_lat_fifo_pop,
    output logic                  arb_idle,
    output logic                  rsp_underflow
);

`ifdef SDP_RDARB_SECONDARY_MEMIF_EN
    localparam int NFIFO = 2;
`else
    localparam int NFIFO = 1;
`endif
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW      = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW      = PW + 1;
    localparam int CNT_W   = $clog2(NREQ * TAG_DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [IDW-1:0]   tag_mem_r [NFIFO][TAG_DEPTH];
    logic [PW-1:0]    wr_ptr_r  [NFIFO];
    logic [PW-1:0]    rd_ptr_r  [NFIFO];
    logic [CW-1:0]    count_r   [NFIFO];
    logic [NFIFO-1:0] fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;

    logic [IDW-1:0]   last_r, lock_id_r, rr_id_s, gnt_id_s, head_id_s;
    logic             lock_r, rr_found_s, gnt_vld_s, gnt_rt_s;
    logic             push_sel_s, pop_sel_s, sel_empty_s, req_hs_s, rsp_hs_s;
    logic [NREQ-1:0]  elig_s;
    logic [REQ_W-1:0] gnt_pd_s;
    int               best_dist_s, rr_dist_s, pop_cnt_s, cnt_sum_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             underflow_r;

    // Occupancy status of each tag FIFO
    always_comb begin
        for (int f = 0; f < NFIFO; f++) begin
            fifo_full_s[f]  = (count_r[f] == CW'(TAG_DEPTH));
            fifo_empty_s[f] = (count_r[f] == {CW{1'b0}});
        end
    end

    // A requester is eligible only if its target tag FIFO has room
    always_comb begin
        elig_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
`ifdef SDP_RDARB_SECONDARY_MEMIF_EN
            elig_s[i] = req_vld[i] && !fifo_full_s[req_ram_type[i]];
`else
            elig_s[i] = req_vld[i] && !fifo_full_s[0];
`endif
        end
    end

    // Round-robin pick: smallest distance upward from last+1 wins
    always_comb begin
        best_dist_s = NREQ;
        rr_dist_s   = 0;
        rr_id_s     = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            rr_dist_s = (i + NREQ - 1 - int'(last_r)) % NREQ;
            if (elig_s[i] && (rr_dist_s < best_dist_s)) begin
                best_dist_s = rr_dist_s;
                rr_id_s     = IDW'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    assign rr_found_s = (best_dist_s < NREQ);
    // A stalled grant stays on the locked requester until the DMA accepts it
    assign gnt_vld_s  = lock_r ? req_vld[lock_id_r] : rr_found_s;
    assign gnt_id_s   = lock_r ? lock_id_r : rr_id_s;
    assign req_hs_s   = gnt_vld_s && dma_rd_req_rdy;

    // Payload/ram-type mux and per-requester ready
    always_comb begin
        gnt_pd_s = {REQ_W{1'b0}};
        gnt_rt_s = 1'b0;
        req_rdy  = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id_s == IDW'(i)) begin
                gnt_pd_s   = req_pd[i*REQ_W +: REQ_W];
                gnt_rt_s   = req_ram_type[i];
                req_rdy[i] = gnt_vld_s && dma_rd_req_rdy;
            end else begin
                req_rdy[i] = 1'b0;
            end
        end
    end

    assign dma_rd_req_vld = gnt_vld_s;
    assign dma_rd_req_pd  = gnt_pd_s;

`ifdef SDP_RDARB_SECONDARY_MEMIF_EN
    assign push_sel_s          = gnt_rt_s;
    assign pop_sel_s           = dma_rd_rsp_ram_type;
    assign dma_rd_req_ram_type = gnt_rt_s;
`else
    logic unused_ram_type_s;
    assign unused_ram_type_s   = gnt_rt_s ^ dma_rd_rsp_ram_type;
    assign push_sel_s          = 1'b0;
    assign pop_sel_s           = 1'b0;
    assign dma_rd_req_ram_type = 1'b0;
`endif

    // Head of the tag FIFO that the current response belongs to
    always_comb begin
        head_id_s   = {IDW{1'b0}};
        sel_empty_s = 1'b1;
        for (int f = 0; f < NFIFO; f++) begin
            if (int'(pop_sel_s) == f) begin
                head_id_s   = tag_mem_r[f][rd_ptr_r[f]];
                sel_empty_s = fifo_empty_s[f];
            end else begin
                sel_empty_s = sel_empty_s;
            end
        end
    end

    // Route the response to the head requester. An empty FIFO blocks it.
    always_comb begin
        rsp_vld        = {NREQ{1'b0}};
        dma_rd_rsp_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_empty_s && (head_id_s == IDW'(i))) begin
                rsp_vld[i]     = dma_rd_rsp_vld;
                dma_rd_rsp_rdy = rsp_rdy[i];
            end else begin
                rsp_vld[i] = 1'b0;
            end
        end
    end

    assign rsp_pd   = dma_rd_rsp_pd;
    assign rsp_hs_s = dma_rd_rsp_vld && dma_rd_rsp_rdy;

    // Per-FIFO push/pop strobes
    always_comb begin
        for (int f = 0; f < NFIFO; f++) begin
            fifo_push_s[f] = req_hs_s && (int'(push_sel_s) == f);
            fifo_pop_s[f]  = rsp_hs_s && (int'(pop_sel_s) == f);
        end
    end

    // Tag FIFO storage (contents need no reset, occupancy is tracked by count)
    always_ff @(posedge nvdla_core_clk) begin
        for (int f = 0; f < NFIFO; f++) begin
            if (fifo_push_s[f]) begin
                tag_mem_r[f][wr_ptr_r[f]] <= gnt_id_s;
            end
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push+pop keeps the count
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            for (int f = 0; f < NFIFO; f++) begin
                wr_ptr_r[f] <= {PW{1'b0}};
                rd_ptr_r[f] <= {PW{1'b0}};
                count_r[f]  <= {CW{1'b0}};
            end
        end else begin
            for (int f = 0; f < NFIFO; f++) begin
                if (fifo_push_s[f]) wr_ptr_r[f] <= wr_ptr_r[f] + PW'(1);
                if (fifo_pop_s[f])  rd_ptr_r[f] <= rd_ptr_r[f] + PW'(1);
                if (fifo_push_s[f] && !fifo_pop_s[f]) begin
                    count_r[f] <= count_r[f] + CW'(1);
                end else if (fifo_pop_s[f] && !fifo_push_s[f]) begin
                    count_r[f] <= count_r[f] - CW'(1);
                end else begin
                    count_r[f] <= count_r[f];
                end
            end
        end
    end

    // Round-robin pointer and grant lock
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            last_r    <= IDW'(NREQ - 1);
            lock_r    <= 1'b0;
            lock_id_r <= {IDW{1'b0}};
        end else if (req_hs_s) begin
            last_r <= gnt_id_s;
            lock_r <= 1'b0;
        end else if (gnt_vld_s) begin
            lock_r    <= 1'b1;
            lock_id_r <= gnt_id_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

    // Credit merge: add this cycle's pops, drain one per cycle, saturate
    always_comb begin
        pop_cnt_s = 0;
        for (int i = 0; i < NREQ; i++) begin
            pop_cnt_s = pop_cnt_s + int'(cdt_pop[i]);
        end
        cnt_sum_s  = int'(cnt_r) + pop_cnt_s - ((cnt_r != {CNT_W{1'b0}}) ? 1 : 0);
        cnt_next_s = (cnt_sum_s > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum_s);
    end

    // Credit counter and sticky underflow flag
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            underflow_r <= underflow_r | (dma_rd_rsp_vld & sel_empty_s);
        end
    end

    assign dma_rd_cdt_lat_fifo_pop = (cnt_r != {CNT_W{1'b0}});
    assign rsp_underflow           = underflow_r;
    assign arb_idle                = (&fifo_empty_s) && (cnt_r == {CNT_W{1'b0}}) && !lock_r;

endmodule

// File: tb/tb_sdp_rdma_rd_arb.sv
// ---------------------------------------------------------------------------
// Randomized self-checking bench for sdp_rdma_rd_arb. The reference model
// keeps tag FIFOs as queues, the credit count as an integer and the
// round-robin order as plain modulo arithmetic. Each cycle, every DUT output
// is compared against the model. After that the model advances on the clock
// edge.
// ---------------------------------------------------------------------------
module tb_sdp_rdma_rd_arb;
    localparam int NREQ      = 4;
    localparam int REQ_W     = 79;
    localparam int RSP_W     = 514;
    localparam int TAG_DEPTH = 16;
    localparam int CNT_MAX   = (1 << ($clog2(NREQ * TAG_DEPTH) + 1)) - 1;
`ifdef SDP_RDARB_SECONDARY_MEMIF_EN
    localparam bit SEC = 1'b1;
`else
    localparam bit SEC = 1'b0;
`endif

    logic                  nvdla_core_clk = 1'b0;
    logic                  nvdla_core_rst = 1'b1;
    logic [NREQ-1:0]       req_vld = '0, req_rdy, req_ram_type = '0;
    logic [NREQ*REQ_W-1:0] req_pd = '0;
    logic                  dma_rd_req_vld, dma_rd_req_rdy = 1'b0, dma_rd_req_ram_type;
    logic [REQ_W-1:0]      dma_rd_req_pd;
    logic                  dma_rd_rsp_vld = 1'b0, dma_rd_rsp_rdy, dma_rd_rsp_ram_type = 1'b0;
    logic [RSP_W-1:0]      dma_rd_rsp_pd = '0, rsp_pd;
    logic [NREQ-1:0]       rsp_vld, rsp_rdy = '0, cdt_pop = '0;
    logic                  dma_rd_cdt_lat_fifo_pop, arb_idle, rsp_underflow;

    sdp_rdma_rd_arb #(.NREQ(NREQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rst(nvdla_core_rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_pd(req_pd), .req_ram_type(req_ram_type),
        .dma_rd_req_vld(dma_rd_req_vld), .dma_rd_req_rdy(dma_rd_req_rdy),
        .dma_rd_req_pd(dma_rd_req_pd), .dma_rd_req_ram_type(dma_rd_req_ram_type),
        .dma_rd_rsp_vld(dma_rd_rsp_vld), .dma_rd_rsp_rdy(dma_rd_rsp_rdy),
        .dma_rd_rsp_pd(dma_rd_rsp_pd), .dma_rd_rsp_ram_type(dma_rd_rsp_ram_type),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_pd(rsp_pd), .cdt_pop(cdt_pop),
        .dma_rd_cdt_lat_fifo_pop(dma_rd_cdt_lat_fifo_pop), .arb_idle(arb_idle),
        .rsp_underflow(rsp_underflow)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [RSP_W-1:0] got, input logic [RSP_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               q_mc[$];
    int               q_cv[$];
    int               m_last, m_lock_id, m_cnt, m_g;
    bit               m_lock, m_uf, m_gv;
    logic [REQ_W-1:0] m_lock_pd;

    function automatic int qsize(input bit sel);
        return sel ? q_cv.size() : q_mc.size();
    endfunction

    function automatic int qhead(input bit sel);
        return sel ? q_cv[0] : q_mc[0];
    endfunction

    function automatic bit req_target(input int i);
        return SEC ? req_ram_type[i] : 1'b0;
    endfunction

    function automatic void model_reset();
        q_mc.delete(); q_cv.delete();
        m_last = NREQ - 1; m_lock = 1'b0; m_lock_id = 0; m_cnt = 0; m_uf = 1'b0;
    endfunction

    // Who wins this cycle, by the round-robin / lock rules
    function automatic void model_grant();
        m_gv = 1'b0; m_g = 0;
        if (m_lock) begin
            m_gv = 1'b1; m_g = m_lock_id;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (!m_gv && req_vld[c] && qsize(req_target(c)) < TAG_DEPTH) begin
                    m_gv = 1'b1; m_g = c;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        bit               rsel;
        int               h;
        logic [NREQ-1:0]  e_rdy, e_rspv;
        logic             e_rsprdy;
        model_grant();
        check_eq("req_vld", RSP_W'(dma_rd_req_vld), RSP_W'(m_gv));
        e_rdy = (m_gv && dma_rd_req_rdy) ? NREQ'(1 << m_g) : '0;
        check_eq("req_rdy", RSP_W'(req_rdy), RSP_W'(e_rdy));
        if (m_gv) begin
            check_eq("req_pd", RSP_W'(dma_rd_req_pd), RSP_W'(req_pd[m_g*REQ_W +: REQ_W]));
            check_eq("req_ram_type", RSP_W'(dma_rd_req_ram_type), RSP_W'(req_target(m_g)));
        end
        if (m_lock) check_eq("pd_hold", RSP_W'(dma_rd_req_pd), RSP_W'(m_lock_pd));
        rsel = SEC ? dma_rd_rsp_ram_type : 1'b0;
        e_rspv = '0; e_rsprdy = 1'b0;
        if (qsize(rsel) > 0) begin
            h = qhead(rsel);
            e_rspv   = dma_rd_rsp_vld ? NREQ'(1 << h) : '0;
            e_rsprdy = rsp_rdy[h];
        end
        check_eq("rsp_vld", RSP_W'(rsp_vld), RSP_W'(e_rspv));
        check_eq("dma_rsp_rdy", RSP_W'(dma_rd_rsp_rdy), RSP_W'(e_rsprdy));
        check_eq("rsp_pd", rsp_pd, dma_rd_rsp_pd);
        check_eq("cdt_pop_out", RSP_W'(dma_rd_cdt_lat_fifo_pop), RSP_W'(m_cnt != 0));
        check_eq("arb_idle", RSP_W'(arb_idle),
                 RSP_W'(q_mc.size() == 0 && q_cv.size() == 0 && m_cnt == 0 && !m_lock));
        check_eq("rsp_underflow", RSP_W'(rsp_underflow), RSP_W'(m_uf));
    endtask

    task automatic model_update();
        bit rsel;
        int h;
        model_grant();
        rsel = SEC ? dma_rd_rsp_ram_type : 1'b0;
        if (qsize(rsel) > 0) begin
            h = qhead(rsel);
            if (dma_rd_rsp_vld && rsp_rdy[h]) begin
                if (rsel) void'(q_cv.pop_front()); else void'(q_mc.pop_front());
            end
        end else if (dma_rd_rsp_vld) begin
            m_uf = 1'b1;
        end
        if (m_gv && dma_rd_req_rdy) begin
            if (req_target(m_g)) q_cv.push_back(m_g); else q_mc.push_back(m_g);
            m_last = m_g; m_lock = 1'b0;
        end else if (m_gv) begin
            m_lock = 1'b1; m_lock_id = m_g; m_lock_pd = req_pd[m_g*REQ_W +: REQ_W];
        end else begin
            m_lock = 1'b0;
        end
        m_cnt = m_cnt + $countones(cdt_pop) - ((m_cnt != 0) ? 1 : 0);
        if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int p_vld, input int p_rdy, input int p_rsp, input int p_rsprdy, input int p_cdt);
        logic [575:0] w;
        for (int i = 0; i < NREQ; i++) begin
            if (!(m_lock && i == m_lock_id)) begin
                req_vld[i]      = ($urandom_range(99) < p_vld);
                req_ram_type[i] = $urandom_range(1);
                req_pd[i*REQ_W +: REQ_W] = REQ_W'({$urandom, $urandom, $urandom});
            end else begin
                req_vld[i] = 1'b1;
            end
            rsp_rdy[i] = ($urandom_range(99) < p_rsprdy);
            cdt_pop[i] = ($urandom_range(99) < p_cdt);
        end
        dma_rd_req_rdy      = ($urandom_range(99) < p_rdy);
        dma_rd_rsp_vld      = ($urandom_range(99) < p_rsp);
        dma_rd_rsp_ram_type = $urandom_range(1);
        for (int j = 0; j < 18; j++) w[j*32 +: 32] = $urandom;
        dma_rd_rsp_pd = w[RSP_W-1:0];
    endtask

    task automatic step(input int p_vld, input int p_rdy, input int p_rsp, input int p_rsprdy, input int p_cdt);
        @(negedge nvdla_core_clk);
        drive(p_vld, p_rdy, p_rsp, p_rsprdy, p_cdt);
        #1;
        check_outputs();
        @(posedge nvdla_core_clk);
        model_update();
    endtask

    task automatic run(input int n, input int p_vld, input int p_rdy, input int p_rsp, input int p_rsprdy, input int p_cdt);
        for (int c = 0; c < n; c++) step(p_vld, p_rdy, p_rsp, p_rsprdy, p_cdt);
    endtask

    task automatic do_reset();
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b1;
        req_vld = '0; dma_rd_req_rdy = 1'b0; dma_rd_rsp_vld = 1'b0; rsp_rdy = '0; cdt_pop = '0;
        repeat (2) @(posedge nvdla_core_clk);
        model_reset();
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        run(3, 0, 0, 0, 0, 0);          // reset state, idle inputs
        run(5, 100, 100, 0, 0, 0);      // back-to-back grants 0,1,2,3,0
        run(6, 100, 0, 0, 0, 0);        // stalled grant held with stable pd
        run(400, 50, 50, 50, 80, 20);   // mixed traffic
        run(40, 100, 100, 0, 0, 0);     // fill tag FIFOs to full
        run(40, 0, 0, 100, 100, 0);     // drain, then response on empty FIFO
        run(4, 0, 0, 0, 0, 0);          // underflow stays set
        do_reset();
        run(2, 0, 0, 0, 0, 0);          // underflow cleared by reset
        run(1, 0, 0, 0, 0, 100);        // four pops at once
        run(6, 0, 0, 0, 0, 0);          // exactly four merged pops, then idle
        run(60, 0, 0, 0, 0, 100);       // credit counter saturation
        run(150, 0, 0, 0, 0, 0);        // drain credits
        run(2000, 70, 60, 60, 70, 15);  // long random run
        do_reset();
        run(500, 80, 40, 30, 50, 30);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
